gray_ctrl: RTL
==============

# gray_ctrl

Sequencing controller for the 3-bit Gray-code counter. Accepts a run command for N steps, drives the counter's enable and reset, supports hold and abort, and checks every step the counter takes against the Gray sequence. Each step is a single-bit transition in the order 000→001→011→010→110→111→101→100→000. The controller sits between the command source and one counter instance. It counts wraps and flags sequence errors.

## Interface
Parameters:
- STEP_W, 4, width of the step-count command; max run is 2^STEP_W−1 steps.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset sampled on Clk rising edge.
- Start  in  1  run request; sampled only in IDLE.
- Steps  in  STEP_W  number of counter steps for this run; sampled with Start.
- Hold  in  1  pause; gates GrayEn while in RUN.
- ClearReq  in  1  abort and clear counter and checker; accepted in any state except CLEAR.
- GrayOut  in  3  counter output.
- GrayOvf  in  1  counter overflow flag, sticky in the counter.
- GrayEn  out  1  counter enable.
- GrayReset  out  1  counter synchronous reset.
- Busy  out  1  high in RUN and CLEAR.
- Done  out  1  one-cycle pulse at run completion.
- Wraps  out  4  count of observed 100→000 transitions; saturates at 15.
- SeqErr  out  1  sticky sequence-check failure.

## Operation
- States: IDLE, RUN, CLEAR, DONE. Internal registers:
  - Rem (STEP_W bits), steps left in the run.
  - Last (3 bits), last Gray value checked.
  - EnD, GrayEn delayed one cycle.
- Combinational outputs:
  - GrayEn = (state==RUN) & ~Hold.
  - GrayReset = Reset | (state==CLEAR).
  - Busy = RUN | CLEAR.
  - Done = (state==DONE).
- Transitions, in priority order:
  - ClearReq in IDLE/RUN/DONE → CLEAR.
  - CLEAR → IDLE, unconditionally, after exactly one cycle.
  - IDLE with Start and Steps≠0 → RUN; Rem ← Steps.
  - IDLE with Start and Steps=0 → DONE.
  - RUN with GrayEn: Rem ← Rem−1; if Rem==1 → DONE.
  - RUN with Hold: no change.
  - DONE → IDLE.
- Start outside IDLE is ignored. ClearReq and Start in the same cycle: ClearReq wins. An aborted run produces no Done.
- Checker:
  - The cycle after each GrayEn cycle (EnD=1), compare GrayOut with next_gray(Last).
  - Mismatch → SeqErr ← 1.
  - Always Last ← GrayOut.
- Wrap detection:
  - Applies when EnD=1 and Last==100 and GrayOut==000.
  - Wraps ← min(Wraps+1, 15).
  - If GrayOvf==0 in that cycle, SeqErr ← 1.
- In CLEAR: Last ← 000, Wraps ← 0, SeqErr ← 0, Rem ← 0, EnD ← 0.
- Reset values: state IDLE, Rem 0, Last 000, EnD 0, Wraps 0, SeqErr 0. Therefore GrayEn 0, Busy 0, Done 0, GrayReset 1 while Reset is held.
- Reset mid-run: abandon immediately, no Done. The counter is reset in the same cycle.

## Timing
- Start sampled at edge k → RUN from cycle k+1; GrayEn high in cycle k+1 if Hold=0.
- Steps=N, no Hold:
  - GrayEn high for cycles k+1..k+N.
  - DONE (Done=1, Busy=0) in cycle k+N+1.
  - IDLE in k+N+2.
- The check of the last step happens in the DONE cycle. SeqErr/Wraps are final from cycle k+N+2.
- Each Hold cycle in RUN adds one cycle of latency. Hold in IDLE/DONE has no effect.
- Steps=0: Done in cycle k+1, no GrayEn.
- ClearReq at edge j → GrayReset=1 in cycle j+1, IDLE in j+2. The counter reads 000 from j+2.
- Back-to-back runs: Start may be asserted in the DONE cycle but is ignored; it is accepted from IDLE only.

## Test plan
- Reset, Start with Steps=3 → GrayEn high 3 cycles; GrayOut 001, 011, 010; Done one cycle later; SeqErr 0, Wraps 0.
- After Reset, Start with Steps=9 → GrayOut passes 100→000 with GrayOvf=1; Wraps=1; final GrayOut 001; SeqErr 0.
- Start with Steps=4, Hold high for 2 cycles after the 2nd step → exactly 4 GrayEn cycles over 6 RUN cycles; Done in cycle k+7.
- ClearReq during the 3rd cycle of a Steps=10 run → GrayReset one cycle; no Done; IDLE two cycles later; GrayOut 000, Wraps 0, SeqErr 0.
- Start with Steps=0 → Done in the next cycle, GrayEn never high; Start+ClearReq together in IDLE → CLEAR, no run.
- Bench model returns 011 after first enable from 000 → SeqErr=1, held through further runs, cleared only by ClearReq or Reset.

Source files
------------

// File: rtl/gray_ctrl.sv
// gray_ctrl: sequencing controller for a 3-bit Gray-code counter.
//
// Runs the counter for a commanded number of steps and supports hold and
// abort. Every step the counter takes is checked against the Gray order
// 000->001->011->010->110->111->101->100->000. The controller counts wraps
// and keeps a sticky sequence-error flag.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_reset       synchronous active-high reset
//   i_start       run request, sampled only in IDLE
//   i_steps       step count for the run, sampled with i_start
//   i_hold        pauses the counter while running
//   i_clear_req   abort and clear counter and checker (ignored in CLEAR)
//   i_gray_out    counter value
//   i_gray_ovf    counter overflow flag (sticky inside the counter)
//   o_gray_en     counter enable
//   o_gray_reset  counter synchronous reset
//   o_busy        high in RUN and CLEAR
//   o_done        one-cycle pulse when a run completes
//   o_wraps       observed 100->000 transitions, saturating at 15
//   o_seq_err     sticky sequence-check failure
//   o_state       current FSM state (IDLE=0, RUN=1, CLEAR=2, DONE=3)
//
// Command protocol: i_start is a request qualified by the FSM being in
// IDLE. There is no back-pressure signal; a request outside IDLE is dropped.
// Each accepted request answers with exactly one o_done pulse, unless
// ClearReq or reset aborts the run. A run with zero steps still answers
// with o_done.
module gray_ctrl #(
  parameter int STEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_steps,
  input  logic              i_hold,
  input  logic              i_clear_req,
  input  logic [2:0]        i_gray_out,
  input  logic              i_gray_ovf,
  output logic              o_gray_en,
  output logic              o_gray_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_wraps,
  output logic              o_seq_err,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [STEP_W-1:0] r_rem;
  logic [STEP_W-1:0] w_next_rem;
  logic [2:0]        r_last;
  logic              r_en_d;
  logic [3:0]        r_wraps;
  logic              r_seq_err;
  logic              w_wrap;

  // Successor of a value in the 3-bit Gray order.
  function automatic logic [2:0] next_gray(input logic [2:0] g);
    logic [2:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000; // 3'b100 wraps to zero
    endcase
    return n;
  endfunction

  assign o_gray_en    = (r_state == S_RUN) & ~i_hold;
  assign o_gray_reset = i_reset | (r_state == S_CLEAR);
  assign o_busy       = (r_state == S_RUN) | (r_state == S_CLEAR);
  assign o_done       = (r_state == S_DONE);
  assign o_wraps      = r_wraps;
  assign o_seq_err    = r_seq_err;
  assign o_state      = r_state;

  // Next state and remaining-step count.
  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (i_clear_req) begin
          w_next_state = S_CLEAR;
        end else if (i_start) begin
          if (i_steps != '0) begin
            w_next_state = S_RUN;
            w_next_rem   = i_steps;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (i_clear_req) begin
          w_next_state = S_CLEAR;
        end else if (!i_hold) begin
          w_next_rem = r_rem - STEP_W'(1);
          if (r_rem == STEP_W'(1)) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        w_next_state = S_IDLE;
        w_next_rem   = '0;
      end
      default: begin // S_DONE
        if (i_clear_req) begin
          w_next_state = S_CLEAR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // A wrap is seen when a checked step moves from 100 to 000.
  assign w_wrap = r_en_d & (r_last == 3'b100) & (i_gray_out == 3'b000);

  // Step checker. The counter moves on the edge that ends an enable cycle, so
  // the new value is checked one cycle later (r_en_d). r_last follows the
  // counter every cycle; the counter is frozen outside enable cycles, so r_last
  // holds the pre-step value whenever a check happens.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == S_CLEAR)) begin
      r_last    <= 3'b000;
      r_en_d    <= 1'b0;
      r_wraps   <= 4'd0;
      r_seq_err <= 1'b0;
    end else begin
      r_en_d <= o_gray_en;
      r_last <= i_gray_out;
      if (r_en_d && (i_gray_out != next_gray(r_last))) begin
        r_seq_err <= 1'b1;
      end
      if (w_wrap) begin
        if (r_wraps != 4'd15) begin
          r_wraps <= r_wraps + 4'd1;
        end
        // The counter must raise its overflow flag when it wraps.
        if (!i_gray_ovf) begin
          r_seq_err <= 1'b1;
        end
      end
    end
  end

endmodule
